// File: rtl/nn_feeder_if.sv
// nn_feeder_if
//   Bundles the two handshake sides of the feeder:
//   - producer side: s_valid/s_ready plus the five beat words s_x..s_w
//   - NN side: in_valid plus data_x/data_h/weight_u/weight_v/weight_w,
//     and the NN response out_valid/out
//   modport slave  : the feeder's view
//   modport master : the view of the surrounding system (producer + NN)
interface nn_feeder_if #(
  parameter int WIDTH = 32
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_x, s_h, s_u, s_v, s_w;

  logic             in_valid;
  logic [WIDTH-1:0] data_x, data_h, weight_u, weight_v, weight_w;

  logic             out_valid;
  logic [WIDTH-1:0] out;

  modport slave (
    input  s_valid, s_x, s_h, s_u, s_v, s_w, out_valid, out,
    output s_ready, in_valid, data_x, data_h, weight_u, weight_v, weight_w
  );

  modport master (
    output s_valid, s_x, s_h, s_u, s_v, s_w, out_valid, out,
    input  s_ready, in_valid, data_x, data_h, weight_u, weight_v, weight_w
  );
endinterface

// File: rtl/nn_feeder.sv
// nn_feeder
//   Buffers one BEATS-beat pattern from a producer, replays it to the NN as a
//   single gap-free in_valid burst, then counts BEATS out_valid responses.
//   Ports:
//     clk, rst_n   : clock, synchronous active-low reset
//     bus          : nn_feeder_if.slave (producer handshake + NN bus)
//     done         : one-cycle pulse when a pattern closes
//     err_proto    : sticky, out_valid seen outside WAIT
//     err_timeout  : sticky, WAIT ran out before BEATS responses
module nn_feeder #(
  parameter int WIDTH   = 32,
  parameter int BEATS   = 9,
  parameter int H_BEATS = 3,
  parameter int MAX_LAT = 1000
)(
  input  logic        clk,
  input  logic        rst_n,
  nn_feeder_if.slave  bus,
  output logic        done,
  output logic        err_proto,
  output logic        err_timeout
);
  localparam int IW = $clog2(BEATS + 1);
  localparam int LW = $clog2(MAX_LAT + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);
  localparam logic [IW-1:0] END_IDX  = IW'(BEATS);
  localparam logic [IW-1:0] H_LIM    = IW'(H_BEATS);
  localparam logic [LW-1:0] LAT_END  = LW'(MAX_LAT - 1);

  typedef struct packed {
    logic [WIDTH-1:0] x, h, u, v, w;
  } beat_t;

  typedef enum logic [1:0] {LOAD, SEND, WAIT, DONE} state_t;

  state_t           st_q;
  logic [IW-1:0]    wr_q, rd_q, cnt_q;
  logic [LW-1:0]    lat_q;
  logic             vld_q, done_q, errp_q, errt_q;
  beat_t            out_q;
  beat_t            mem_q [BEATS];

  logic             acc_d;
  beat_t            beat_d, first_d;

  // The response word is only counted, never looked at.
  logic unused_out;
  assign unused_out = ^bus.out;

  // Gated by rst_n so nothing is accepted in a reset cycle.
  assign bus.s_ready = rst_n && (st_q == LOAD);
  assign acc_d       = bus.s_valid && bus.s_ready;

  // Beats past the recurrent-state window carry no meaningful h.
  assign beat_d = '{x: bus.s_x,
                    h: (wr_q < H_LIM) ? bus.s_h : '0,
                    u: bus.s_u, v: bus.s_v, w: bus.s_w};

  // First burst word: with a single-beat pattern the entry is being written
  // on the same edge, so take it straight from the producer.
  assign first_d = (wr_q == '0) ? beat_d : mem_q[0];

  // Buffer is not reset; each pattern overwrites every entry.
  always_ff @(posedge clk) begin
    if (acc_d) mem_q[wr_q] <= beat_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= LOAD;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      lat_q  <= '0;
      vld_q  <= 1'b0;
      out_q  <= '0;
      done_q <= 1'b0;
      errp_q <= 1'b0;
      errt_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.out_valid && st_q != WAIT) errp_q <= 1'b1;

      case (st_q)
        LOAD: if (acc_d) begin
          if (wr_q == LAST_IDX) begin
            // Entry 0 goes out on this edge, so the read index continues at 1.
            wr_q  <= '0;
            rd_q  <= IW'(1);
            vld_q <= 1'b1;
            out_q <= first_d;
            st_q  <= SEND;
          end else begin
            wr_q <= wr_q + 1'b1;
          end
        end

        SEND: begin
          if (rd_q == END_IDX) begin
            rd_q  <= '0;
            vld_q <= 1'b0;
            out_q <= '0;
            st_q  <= WAIT;
          end else begin
            out_q <= mem_q[rd_q];
            rd_q  <= rd_q + 1'b1;
          end
        end

        WAIT: begin
          // Success is checked first so a final response on the last
          // allowed cycle is not reported as a timeout.
          if (bus.out_valid && cnt_q == LAST_IDX) begin
            done_q <= 1'b1;
            st_q   <= DONE;
          end else if (lat_q == LAT_END) begin
            errt_q <= 1'b1;
            done_q <= 1'b1;
            st_q   <= DONE;
          end else begin
            lat_q <= lat_q + 1'b1;
            if (bus.out_valid) cnt_q <= cnt_q + 1'b1;
          end
        end

        DONE: begin
          wr_q  <= '0;
          rd_q  <= '0;
          cnt_q <= '0;
          lat_q <= '0;
          st_q  <= LOAD;
        end

        default: st_q <= LOAD;
      endcase
    end
  end

  assign bus.in_valid = vld_q;
  assign bus.data_x   = out_q.x;
  assign bus.data_h   = out_q.h;
  assign bus.weight_u = out_q.u;
  assign bus.weight_v = out_q.v;
  assign bus.weight_w = out_q.w;

  assign done        = done_q;
  assign err_proto   = errp_q;
  assign err_timeout = errt_q;
endmodule

// File: tb/tb_nn_feeder.sv
// tb_nn_feeder
//   Directed bench for nn_feeder (BEATS=9, H_BEATS=3, MAX_LAT=20).
//   Inputs change 1 time unit after a rising edge; outputs are checked in
//   the same window, before the next edge.
module tb_nn_feeder;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic done, err_proto, err_timeout;
  int   nvec = 0;
  int   nerr = 0;

  nn_feeder_if #(.WIDTH(32)) bus();

  nn_feeder #(
    .WIDTH(32), .BEATS(9), .H_BEATS(3), .MAX_LAT(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .done(done), .err_proto(err_proto), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_beat(input int base, input int i);
    bus.s_valid = 1'b1;
    bus.s_x = base + i;
    bus.s_h = (i < 3) ? 32'h3F80_0000 + base : 32'hDEAD_0000 + i;
    bus.s_u = base + i + 16;
    bus.s_v = base + i + 32;
    bus.s_w = base + i + 48;
  endtask

  // Nine beats; optionally a 5-cycle producer stall after beat 4.
  task automatic load(input int base, input bit gap);
    for (int i = 0; i < 9; i++) begin
      drive_beat(base, i);
      chk1("s_ready_load", bus.s_ready, 1'b1);
      step();
      if (gap && i == 4) begin
        bus.s_valid = 1'b0;
        bus.s_x     = 32'h0000_0BAD;
        for (int g = 0; g < 5; g++) begin
          chk1("s_ready_gap", bus.s_ready, 1'b1);
          chk1("in_valid_gap", bus.in_valid, 1'b0);
          step();
        end
      end
    end
    bus.s_valid = 1'b0;
  endtask

  // Expect the nine-cycle burst starting now; optional stray out_valid on
  // burst cycles 2 and 3. Ends on the first WAIT cycle.
  task automatic burst(input int base, input bit stray);
    for (int k = 0; k < 9; k++) begin
      bus.out_valid = stray && (k == 2 || k == 3);
      chk1 ("in_valid_burst", bus.in_valid, 1'b1);
      chk1 ("s_ready_send", bus.s_ready, 1'b0);
      chk32("data_x", bus.data_x, base + k);
      chk32("data_h", bus.data_h, (k < 3) ? 32'h3F80_0000 + base : 32'h0);
      chk32("weight_u", bus.weight_u, base + k + 16);
      chk32("weight_v", bus.weight_v, base + k + 32);
      chk32("weight_w", bus.weight_w, base + k + 48);
      step();
    end
    bus.out_valid = 1'b0;
    chk1 ("in_valid_end", bus.in_valid, 1'b0);
    chk32("data_x_idle", bus.data_x, 32'h0);
    chk32("data_h_idle", bus.data_h, 32'h0);
    chk32("weight_w_idle", bus.weight_w, 32'h0);
  endtask

  // From the first WAIT cycle: idle `delay` cycles, then n contiguous
  // responses; done must appear exactly on the cycle after the last one.
  task automatic respond(input int delay, input int n);
    for (int c = 0; c < delay + n; c++) begin
      bus.out_valid = (c >= delay);
      chk1("done_early", done, 1'b0);
      chk1("s_ready_wait", bus.s_ready, 1'b0);
      step();
    end
    bus.out_valid = 1'b0;
    chk1("done_pulse", done, 1'b1);
    chk1("s_ready_done", bus.s_ready, 1'b0);
    step();
    chk1("done_clear", done, 1'b0);
    chk1("s_ready_reload", bus.s_ready, 1'b1);
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.out_valid = 1'b0; bus.out = 32'h0;
    bus.s_x = '0; bus.s_h = '0; bus.s_u = '0; bus.s_v = '0; bus.s_w = '0;

    // Reset state
    rst_n = 1'b0;
    step(); step();
    chk1 ("rst_s_ready", bus.s_ready, 1'b0);
    chk1 ("rst_in_valid", bus.in_valid, 1'b0);
    chk1 ("rst_done", done, 1'b0);
    chk1 ("rst_err_proto", err_proto, 1'b0);
    chk1 ("rst_err_timeout", err_timeout, 1'b0);
    chk32("rst_data_x", bus.data_x, 32'h0);
    chk32("rst_weight_w", bus.weight_w, 32'h0);
    rst_n = 1'b1;
    #1;
    chk1("load_s_ready", bus.s_ready, 1'b1);

    // Back-to-back load, NN answers after 4 cycles
    load(0, 1'b0);
    burst(0, 1'b0);
    respond(4, 9);
    chk1("t1_err_proto", err_proto, 1'b0);
    chk1("t1_err_timeout", err_timeout, 1'b0);

    // Producer stall mid-load
    load(64, 1'b1);
    burst(64, 1'b0);
    respond(0, 9);
    chk1("t2_err_proto", err_proto, 1'b0);
    chk1("t2_err_timeout", err_timeout, 1'b0);

    // Only 8 responses: timeout on WAIT cycle 19, done on cycle 20
    load(128, 1'b0);
    burst(128, 1'b0);
    for (int c = 0; c < 20; c++) begin
      bus.out_valid = (c >= 2 && c < 10);
      chk1("to_done_early", done, 1'b0);
      step();
    end
    bus.out_valid = 1'b0;
    chk1("to_done", done, 1'b1);
    chk1("to_err_timeout", err_timeout, 1'b1);
    step();
    chk1("to_done_clear", done, 1'b0);
    chk1("to_sticky", err_timeout, 1'b1);
    chk1("to_s_ready", bus.s_ready, 1'b1);

    // Reset after 3 SEND cycles
    load(200, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk32("pre_rst_data_x", bus.data_x, 200 + k);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk1("rst2_s_ready_low", bus.s_ready, 1'b0);
    step();
    rst_n = 1'b1;
    #1;
    chk1 ("rst2_in_valid", bus.in_valid, 1'b0);
    chk1 ("rst2_s_ready", bus.s_ready, 1'b1);
    chk1 ("rst2_err_timeout", err_timeout, 1'b0);
    chk1 ("rst2_err_proto", err_proto, 1'b0);
    chk32("rst2_data_x", bus.data_x, 32'h0);

    // Partial load of 4 beats discarded by another reset
    for (int i = 0; i < 4; i++) begin
      drive_beat(400, i);
      step();
    end
    bus.s_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;

    // Fresh full pattern completes normally
    load(300, 1'b0);
    burst(300, 1'b0);
    respond(3, 9);
    chk1("t5_err_proto", err_proto, 1'b0);
    chk1("t5_err_timeout", err_timeout, 1'b0);

    // Stray out_valid during SEND: flagged, not counted
    load(500, 1'b0);
    burst(500, 1'b1);
    chk1("t4_err_proto", err_proto, 1'b1);
    respond(1, 9);
    chk1("t4_err_timeout", err_timeout, 1'b0);
    chk1("t4_proto_sticky", err_proto, 1'b1);

    // 9th response on the timeout cycle: success wins
    load(600, 1'b0);
    burst(600, 1'b0);
    respond(11, 9);
    chk1("t6_err_timeout", err_timeout, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
